int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_pkg.sv | 11 +
 rtl/int_prio_enc.sv | 13 +
 rtl/int_ctrl.sv | 126 ++++++++++++
 tb/tb_int_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants and FSM encoding for the interrupt controller.
package int_ctrl_pkg;
    localparam logic [31:0] INT_VEC_BASE = 32'h0000_0800;
    localparam int          INT_NUM_SRC  = 3;
    typedef enum logic [1:0] {
        INT_ST_IDLE    = 2'd0,
        INT_ST_TAKE    = 2'd1,
        INT_ST_SERVICE = 2'd2,
        INT_ST_RETURN  = 2'd3
    } int_state_e;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: fixed-priority encoder, bit 2 highest.
module int_prio_enc
    import int_ctrl_pkg::*;
(
    input  logic [INT_NUM_SRC-1:0] req,
    output logic                   valid,
    output logic [1:0]             idx
);
    always_comb begin
        valid = |req;
        idx   = req[2] ? 2'd2 : (req[1] ? 2'd1 : 2'd0);
    end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: 3-source edge-triggered interrupt controller with mask and EPC save/restore.
// Define INT_NESTED_EN for strictly-higher-priority preemption with a 3-deep EPC stack.
module int_ctrl
    import int_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INT_NUM_SRC-1:0] irq_in,
    input  logic                   ins_valid,
    input  logic [31:0]            pc_next,
    input  logic                   eret,
    input  logic                   mask_we,
    input  logic [INT_NUM_SRC-1:0] mask_wdata,
    output logic                   int_take,
    output logic [31:0]            int_vector,
    output logic                   epc_restore,
    output logic [31:0]            epc,
    output logic [INT_NUM_SRC-1:0] in_service,
    output logic [INT_NUM_SRC-1:0] pending,
    output logic [INT_NUM_SRC-1:0] mask
);
    int_state_e state_q, state_d;
    logic [INT_NUM_SRC-1:0] irq_prev_q, pending_q, pending_d, in_service_q, in_service_d;
    logic [INT_NUM_SRC-1:0] mask_q, mask_d, win_oh, cur_oh;
    logic [31:0] epc_q, epc_d, restore_epc;
    logic int_take_q, int_take_d, epc_restore_q, epc_restore_d;
    logic req_valid, cur_valid, take, preempt, eret_go, pop;
    logic [1:0] req_idx, cur_idx;

    int_prio_enc u_req (.req(pending_q & mask_q), .valid(req_valid), .idx(req_idx));
    // Innermost level is always the highest in-service bit, since nesting only goes upward.
    int_prio_enc u_cur (.req(in_service_q), .valid(cur_valid), .idx(cur_idx));

`ifdef INT_NESTED_EN
    logic [31:0] stack_q [3];
    logic [31:0] stack_d [3];
    logic [1:0]  sp_q, sp_d;

    always_comb begin
        preempt     = state_q == INT_ST_SERVICE && !eret && ins_valid && req_valid && req_idx > cur_idx;
        restore_epc = stack_q[sp_q - 2'd1];
        stack_d     = stack_q;
        sp_d        = sp_q;
        if (preempt) begin
            stack_d[sp_q] = epc_q;
            sp_d          = sp_q + 2'd1;
        end else if (pop) begin
            sp_d = sp_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stack_q <= '{default: '0};
            sp_q    <= '0;
        end else begin
            stack_q <= stack_d;
            sp_q    <= sp_d;
        end
    end
`else
    always_comb begin
        preempt     = 1'b0;
        restore_epc = epc_q;
    end
`endif

    always_comb begin
        eret_go      = state_q == INT_ST_SERVICE && eret && cur_valid;
        pop          = state_q == INT_ST_RETURN && |in_service_q;
        take         = (state_q == INT_ST_IDLE && ins_valid && req_valid) || preempt;
        win_oh       = take ? 3'b001 << req_idx : 3'b000;
        cur_oh       = eret_go ? 3'b001 << cur_idx : 3'b000;
        // A fresh edge on the bit being taken wins over its clear.
        pending_d    = (pending_q & ~win_oh) | (irq_in & ~irq_prev_q);
        in_service_d = (in_service_q | win_oh) & ~cur_oh;
        mask_d       = mask_we ? mask_wdata : mask_q;
        epc_d        = take ? pc_next : (pop ? restore_epc : epc_q);
    end

    always_comb begin
        state_d = state_q;
        if (take)
            state_d = INT_ST_TAKE;
        else if (state_q == INT_ST_TAKE)
            state_d = INT_ST_SERVICE;
        else if (eret_go)
            state_d = INT_ST_RETURN;
        else if (state_q == INT_ST_RETURN)
            state_d = pop ? INT_ST_SERVICE : INT_ST_IDLE;
    end

    always_comb begin
        int_take_d    = state_d == INT_ST_TAKE;
        epc_restore_d = state_d == INT_ST_RETURN;
    end

    always_ff @(posedge clk) begin
        irq_prev_q <= irq_in;
        if (rst) begin
            state_q       <= INT_ST_IDLE;
            pending_q     <= '0;
            in_service_q  <= '0;
            mask_q        <= '0;
            epc_q         <= '0;
            int_take_q    <= 1'b0;
            epc_restore_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            in_service_q  <= in_service_d;
            mask_q        <= mask_d;
            epc_q         <= epc_d;
            int_take_q    <= int_take_d;
            epc_restore_q <= epc_restore_d;
        end
    end

    assign int_take    = int_take_q;
    assign int_vector  = int_take_q ? INT_VEC_BASE + {26'd0, cur_idx, 4'd0} : 32'd0;
    assign epc_restore = epc_restore_q;
    assign epc         = epc_q;
    assign in_service  = in_service_q;
    assign pending     = pending_q;
    assign mask        = mask_q;
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed bench; expected take/restore events are queued as stimulus is driven.
module tb_int_ctrl;
    logic        clk = 1'b0, rst, ins_valid, eret, mask_we;
    logic [2:0]  irq_in, mask_wdata, in_service, pending, mask;
    logic [31:0] pc_next, int_vector, epc;
    logic        int_take, epc_restore;
    int          vectors = 0, miscompares = 0;

    typedef struct { logic [31:0] x; logic [31:0] y; } ev_t;
    ev_t exp_take[$], exp_rest[$], mon_e;

    int_ctrl dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .ins_valid(ins_valid), .pc_next(pc_next),
        .eret(eret), .mask_we(mask_we), .mask_wdata(mask_wdata), .int_take(int_take),
        .int_vector(int_vector), .epc_restore(epc_restore), .epc(epc),
        .in_service(in_service), .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: every int_take / epc_restore pulse must match the next queued event.
    always @(negedge clk) begin
        if (int_take || epc_restore) chk("take_restore_overlap", {31'd0, int_take & epc_restore}, 32'd0);
        if (int_take) begin
            vectors++;
            assert (exp_take.size() > 0) else begin
                miscompares++;
                $error("FAIL take_unexpected: vector=%h want no pulse", int_vector);
            end
            if (exp_take.size() > 0) begin
                mon_e = exp_take.pop_front();
                chk("take_vector", int_vector, mon_e.x);
                chk("take_epc", epc, mon_e.y);
            end
        end
        if (epc_restore) begin
            vectors++;
            assert (exp_rest.size() > 0) else begin
                miscompares++;
                $error("FAIL restore_unexpected: epc=%h want no pulse", epc);
            end
            if (exp_rest.size() > 0) begin
                mon_e = exp_rest.pop_front();
                chk("restore_epc", epc, mon_e.x);
                chk("restore_in_service", {29'd0, in_service}, mon_e.y);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; irq_in = 0; ins_valid = 0; pc_next = 0; eret = 0; mask_we = 0; mask_wdata = 0;
        repeat (2) tick;
        rst = 0;
        chk("rst_pending", {29'd0, pending}, 0);
        chk("rst_in_service", {29'd0, in_service}, 0);
        chk("rst_mask", {29'd0, mask}, 0);
        chk("rst_epc", epc, 0);
        chk("rst_int_take", {31'd0, int_take}, 0);
        chk("rst_epc_restore", {31'd0, epc_restore}, 0);

        // single source: edge latched one edge later, taken on the following edge
        mask_we = 1; mask_wdata = 3'b111; tick; mask_we = 0;
        chk("mask_write", {29'd0, mask}, 32'h7);
        ins_valid = 1; pc_next = 32'h40; irq_in = 3'b001;
        exp_take.push_back('{32'h800, 32'h40});
        tick;
        chk("edge_pending", {29'd0, pending}, 32'h1);
        chk("edge_no_take_yet", {31'd0, int_take}, 0);
        tick;
        chk("take_latency", {31'd0, int_take}, 1);
        chk("take_clears_pending", {29'd0, pending}, 0);
        chk("take_sets_in_service", {29'd0, in_service}, 32'h1);
        tick;
        chk("take_one_cycle", {31'd0, int_take}, 0);
        eret = 1; exp_rest.push_back('{32'h40, 32'h0}); tick; eret = 0;
        chk("restore_pulse", {31'd0, epc_restore}, 1);
        tick;
        chk("restore_one_cycle", {31'd0, epc_restore}, 0);
        chk("idle_in_service", {29'd0, in_service}, 0);
        irq_in = 0; tick;

        // simultaneous edges on sources 2 and 1: 2 first, 1 after return
        irq_in = 3'b110; exp_take.push_back('{32'h820, 32'h40});
        tick;
        chk("dual_pending", {29'd0, pending}, 32'h6);
        tick;
        chk("dual_pending_left", {29'd0, pending}, 32'h2);
        chk("dual_in_service", {29'd0, in_service}, 32'h4);
        tick;
        eret = 1; pc_next = 32'h60; exp_rest.push_back('{32'h40, 32'h0}); tick; eret = 0;
        chk("dual_pending_kept", {29'd0, pending}, 32'h2);
        exp_take.push_back('{32'h810, 32'h60});
        tick; tick;
        chk("second_in_service", {29'd0, in_service}, 32'h2);
        chk("second_pending", {29'd0, pending}, 0);
        tick;
        eret = 1; exp_rest.push_back('{32'h60, 32'h0}); tick; eret = 0; tick;
        irq_in = 0; tick;

        // masked edge is retained and taken once the mask opens
        mask_we = 1; mask_wdata = 3'b000; tick; mask_we = 0;
        irq_in = 3'b010; tick;
        tick; tick;
        chk("masked_pending", {29'd0, pending}, 32'h2);
        chk("masked_no_take", {31'd0, int_take}, 0);
        chk("masked_in_service", {29'd0, in_service}, 0);
        pc_next = 32'h80; mask_we = 1; mask_wdata = 3'b010;
        exp_take.push_back('{32'h810, 32'h80});
        tick; mask_we = 0;
        chk("unmask_value", {29'd0, mask}, 32'h2);
        chk("unmask_no_take_yet", {31'd0, int_take}, 0);
        tick;
        chk("unmask_take", {31'd0, int_take}, 1);
        tick;
        eret = 1; exp_rest.push_back('{32'h80, 32'h0}); tick; eret = 0; tick;
        irq_in = 0; mask_we = 1; mask_wdata = 3'b111; tick; mask_we = 0;

        // eret in IDLE and in TAKE is ignored
        eret = 1; tick; tick; eret = 0;
        chk("eret_idle_ignored", {31'd0, epc_restore}, 0);
        irq_in = 3'b001; pc_next = 32'h90; exp_take.push_back('{32'h800, 32'h90});
        tick; tick;
        chk("take_for_eret_test", {31'd0, int_take}, 1);
        eret = 1; tick; eret = 0;
        chk("eret_take_ignored", {31'd0, epc_restore}, 0);
        tick;
        chk("still_in_service", {29'd0, in_service}, 32'h1);
        eret = 1; exp_rest.push_back('{32'h90, 32'h0}); tick; eret = 0; tick;
        irq_in = 0; tick;

        // new edge on the bit being taken, same edge: set wins
        ins_valid = 0; irq_in = 3'b001; tick; irq_in = 0; tick;
        chk("hold_pending", {29'd0, pending}, 32'h1);
        irq_in = 3'b001; ins_valid = 1; pc_next = 32'ha0; exp_take.push_back('{32'h800, 32'ha0});
        tick;
        chk("set_wins_pending", {29'd0, pending}, 32'h1);
        chk("set_wins_in_service", {29'd0, in_service}, 32'h1);
        tick;
        eret = 1; exp_rest.push_back('{32'ha0, 32'h0}); tick; eret = 0;
        pc_next = 32'hb0; exp_take.push_back('{32'h800, 32'hb0});
        tick; tick;
        chk("set_wins_retaken", {29'd0, pending}, 0);
        tick;
        eret = 1; exp_rest.push_back('{32'hb0, 32'h0}); tick; eret = 0; tick;
        irq_in = 0; tick;

        // higher-priority edge during service of source 0
        pc_next = 32'h100; irq_in = 3'b001; exp_take.push_back('{32'h800, 32'h100});
        tick; tick; tick;
        irq_in = 3'b101; pc_next = 32'h804; tick;
        chk("nest_pending", {29'd0, pending}, 32'h4);
`ifdef INT_NESTED_EN
        exp_take.push_back('{32'h820, 32'h804});
        tick;
        chk("nest_in_service", {29'd0, in_service}, 32'h5);
        chk("nest_epc", epc, 32'h804);
        tick;
        eret = 1; exp_rest.push_back('{32'h804, 32'h1}); tick; eret = 0;
        chk("nest_inner_cleared", {29'd0, in_service}, 32'h1);
        tick;
        chk("nest_epc_popped", epc, 32'h100);
        eret = 1; exp_rest.push_back('{32'h100, 32'h0}); tick; eret = 0; tick;
        chk("nest_done", {29'd0, in_service}, 0);
`else
        tick; tick;
        chk("flat_in_service", {29'd0, in_service}, 32'h1);
        chk("flat_pending", {29'd0, pending}, 32'h4);
        eret = 1; exp_rest.push_back('{32'h100, 32'h0}); tick; eret = 0;
        exp_take.push_back('{32'h820, 32'h804});
        tick; tick;
        chk("flat_second", {29'd0, in_service}, 32'h4);
        tick;
        eret = 1; exp_rest.push_back('{32'h804, 32'h0}); tick; eret = 0; tick;
`endif
        irq_in = 0; tick;

        // reset during TAKE aborts the pulse; irq high during reset leaves no edge
        irq_in = 3'b100; pc_next = 32'hc0; exp_take.push_back('{32'h820, 32'hc0});
        tick; tick;
        chk("pre_reset_take", {31'd0, int_take}, 1);
        rst = 1; irq_in = 3'b111; tick;
        chk("reset_int_take", {31'd0, int_take}, 0);
        chk("reset_int_vector", int_vector, 0);
        chk("reset_epc_restore", {31'd0, epc_restore}, 0);
        chk("reset_epc", epc, 0);
        chk("reset_pending", {29'd0, pending}, 0);
        chk("reset_in_service", {29'd0, in_service}, 0);
        chk("reset_mask", {29'd0, mask}, 0);
        tick; rst = 0; tick; tick;
        chk("post_reset_no_edge", {29'd0, pending}, 0);
        chk("post_reset_no_take", {31'd0, int_take}, 0);

        tick;
        chk("events_drained", exp_take.size() + exp_rest.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
